mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port op  input  2  operation code: 00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (multiplicand/dividend a, multiplier/divisor b).
REQ-007 SHALL have ports hi_we, lo_we  input  1  direct write enables for hi/lo (MTHI/MTLO).
REQ-008 SHALL have port wdata  input  WIDTH  data for hi_we/lo_we.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports hi, lo  output  WIDTH  result registers (MFHI/MFLO source).
REQ-012 SHALL have port divzero  output  1  last division had a zero divisor.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 SHALL accept start only in IDLE or DONE; start while busy is ignored.
REQ-015 SHALL latch op, a and b on the accepting edge; later operand changes have no effect.
REQ-016 SHALL multiply by iterative shift-add, one bit per cycle: WIDTH cycles in RUN, {hi,lo} = full 2*WIDTH-bit product.
REQ-017 SHALL divide by restoring division, one bit per cycle: WIDTH cycles in RUN, lo = quotient, hi = remainder.
REQ-018 SHALL have latency: start accepted at edge 0 -> hi/lo updated and done=1 after edge WIDTH+1; done falls after the next edge.
REQ-019 SHALL hold hi/lo at their previous values during RUN.
REQ-020 SHALL, for division with b==0: skip RUN, go to DONE on the next edge, set hi=a, lo=all ones, divzero=1.
REQ-021 SHALL clear divzero when the next operation is accepted.
REQ-022 SHALL apply hi_we/lo_we at the next edge only in IDLE or DONE; writes during RUN are dropped.
REQ-023 SHALL let an accepted start win over hi_we/lo_we in the same cycle; the write is dropped.
REQ-024 SHALL wrap all arithmetic modulo 2^WIDTH per register, with no overflow flag.

Reset
REQ-025 SHALL, on reset=1, immediately (asynchronously) force state IDLE, busy=0, done=0, divzero=0, hi=0, lo=0, internal counters and operand latches to 0.
REQ-026 SHALL abort any operation in progress on reset, discarding its result.
REQ-027 SHALL require reset deasserted on the edge at which a start is to be accepted.

Configuration
REQ-028 SHALL use macro MUL_DIV_UNIT_SIGNED_EN to select signed operation support.
REQ-029 SHALL, when MUL_DIV_UNIT_SIGNED_EN is defined, execute op 10/11 as two's-complement: magnitude arithmetic, product/quotient negated when operand signs differ, remainder takes the dividend's sign, -2^(WIDTH-1)/-1 gives lo=-2^(WIDTH-1), hi=0.
REQ-030 SHALL, when MUL_DIV_UNIT_SIGNED_EN is undefined, ignore op[1] and execute ops 10/11 identically to 00/01; latency is unchanged in both builds.

Verification (WIDTH=32)
REQ-031 SHALL verify MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at edge 0 -> busy edges 1..32, done after edge 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL verify DIVU a=100 b=7 -> lo=14, hi=2, divzero=0.
REQ-033 SHALL verify DIV a=0xFFFFFFF9 b=2 -> signed build: lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned build: lo=0x7FFFFFFC, hi=0x00000001.
REQ-034 SHALL verify DIVU a=5 b=0 -> done after edge 1, hi=5, lo=0xFFFFFFFF, divzero=1; next MULTU 3*4 -> divzero=0, lo=12.
REQ-035 SHALL verify a second start and lo_we=1 (wdata=0x1234) during RUN are ignored, and lo_we in IDLE -> lo=0x1234 after the next edge.
REQ-036 SHALL verify reset asserted mid-RUN at edge 10, between clock edges -> busy=0, hi=lo=0 without waiting for a clock edge, and no done pulse follows.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit : iterative multiply / divide unit with HI/LO result registers.
//
// Multiplication is shift-add and division is restoring division. Each
// retires one bit per cycle over WIDTH cycles. One more cycle then writes the
// result into hi/lo, applying any sign correction at the same time.
//
// Configuration macro: MUL_DIV_UNIT_SIGNED_EN
//   defined   -> op 10 (MULT) and op 11 (DIV) run as two's-complement operations.
//   undefined -> op[1] is ignored, so MULT/DIV behave exactly like MULTU/DIVU.
//
// Ports:
//   clk      in   clock, rising edge active
//   reset    in   asynchronous active-high reset
//   start    in   request a new operation; accepted only in IDLE or DONE
//   op       in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   a, b     in   multiplicand/dividend, multiplier/divisor
//   hi_we    in   direct write of wdata into hi (MTHI)
//   lo_we    in   direct write of wdata into lo (MTLO)
//   wdata    in   data for hi_we/lo_we
//   busy     out  operation in progress
//   done     out  one-cycle completion pulse
//   hi, lo   out  result registers
//   divzero  out  last division had a zero divisor
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);

    localparam int CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CntW-1:0]        cnt_q;
    logic                   isDiv_q;
    logic                   divByZero_q;
    logic                   negRes_q;
    logic                   negRem_q;
    logic [WIDTH-1:0]       opnd_q;
    logic [WIDTH-1:0]       accHi_q;
    logic [WIDTH-1:0]       accLo_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic                   divzero_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   signedOp;
    logic                   aNeg;
    logic                   bNeg;
    logic [WIDTH-1:0]       aMag;
    logic [WIDTH-1:0]       bMag;
    logic                   acceptStart;

    logic [WIDTH:0]         mulSum;
    logic [WIDTH:0]         divShift;
    logic [WIDTH:0]         divDiff;
    logic [WIDTH-1:0]       accHi_d;
    logic [WIDTH-1:0]       accLo_d;
    logic [2*WIDTH-1:0]     prodRaw;
    logic [WIDTH-1:0]       hiFinal_d;
    logic [WIDTH-1:0]       loFinal_d;

`ifdef MUL_DIV_UNIT_SIGNED_EN
    assign signedOp = op[1];
`else
    logic unusedOpHi;
    assign unusedOpHi = op[1];
    assign signedOp   = 1'b0;
`endif

    // The datapath works on magnitudes. Signs are recorded at acceptance and
    // folded back in during the final RUN cycle.
    assign aNeg        = signedOp & a[WIDTH-1];
    assign bNeg        = signedOp & b[WIDTH-1];
    assign aMag        = aNeg ? -a : a;
    assign bMag        = bNeg ? -b : b;
    assign acceptStart = start & (state_q != RUN);

    // One iteration step. Multiply: add the multiplicand into the upper half
    // when the multiplier LSB is set, then shift the whole {carry, hi, lo}
    // right. Divide: shift {rem, quot} left and keep the trial subtraction
    // only when it does not go negative.
    always_comb begin
        mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
        divShift = {accHi_q, accLo_q[WIDTH-1]};
        divDiff  = divShift - {1'b0, opnd_q};
        accHi_d  = accHi_q;
        accLo_d  = accLo_q;
        if (isDiv_q) begin
            if (!divDiff[WIDTH]) begin
                accHi_d = divDiff[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], 1'b1};
            end else begin
                accHi_d = divShift[WIDTH-1:0];
                accLo_d = {accLo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            {accHi_d, accLo_d} = {mulSum, accLo_q[WIDTH-1:1]};
        end
    end

    // Sign correction for the writeback cycle. A most-negative / -1 division
    // needs no special case: its quotient magnitude is 2^(WIDTH-1), and that
    // value is already the required wrapped result.
    always_comb begin
        prodRaw   = {accHi_q, accLo_q};
        hiFinal_d = accHi_q;
        loFinal_d = accLo_q;
        if (isDiv_q) begin
            loFinal_d = negRes_q ? -accLo_q : accLo_q;
            hiFinal_d = negRem_q ? -accHi_q : accHi_q;
        end else if (negRes_q) begin
            {hiFinal_d, loFinal_d} = -prodRaw;
        end
    end

    // Control FSM and all architectural state. A zero-divisor division spends
    // a single cycle in RUN and then goes to DONE. A normal operation spends
    // WIDTH step cycles in RUN plus one writeback cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            isDiv_q     <= 1'b0;
            divByZero_q <= 1'b0;
            negRes_q    <= 1'b0;
            negRem_q    <= 1'b0;
            opnd_q      <= '0;
            accHi_q     <= '0;
            accLo_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            divzero_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (divByZero_q) begin
                        hi_q      <= accLo_q;
                        lo_q      <= '1;
                        divzero_q <= 1'b1;
                        state_q   <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (cnt_q == CntW'(WIDTH)) begin
                        hi_q    <= hiFinal_d;
                        lo_q    <= loFinal_d;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        accHi_q <= accHi_d;
                        accLo_q <= accLo_d;
                        cnt_q   <= cnt_q + CntW'(1);
                    end
                end
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                    if (acceptStart) begin
                        state_q   <= RUN;
                        busy_q    <= 1'b1;
                        divzero_q <= 1'b0;
                        cnt_q     <= '0;
                        isDiv_q   <= op[0];
                        accHi_q   <= '0;
                        negRes_q  <= aNeg ^ bNeg;
                        if (op[0]) begin
                            divByZero_q <= (b == '0);
                            opnd_q      <= bMag;
                            accLo_q     <= (b == '0) ? a : aMag;
                            negRem_q    <= aNeg;
                        end else begin
                            divByZero_q <= 1'b0;
                            opnd_q      <= aMag;
                            accLo_q     <= bMag;
                            negRem_q    <= 1'b0;
                        end
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign divzero = divzero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit : directed self-checking bench for mul_div_unit (WIDTH=32).
// Expected values are hand-computed. The signed DIV/MULT vectors pick their
// expectations from MUL_DIV_UNIT_SIGNED_EN so that one bench covers both builds.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         divzero;

    int checkCount = 0;
    int errorCount = 0;
    int lat;
    int sawDone;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .divzero (divzero)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, let it be accepted on the next edge (edge 0), then
    // scramble the operands to show that they were latched.
    task automatic applyStimulus(input logic [1:0] opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn);
        op    = opIn;
        a     = aIn;
        b     = bIn;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'(($urandom));
    endtask

    // Count edges after edge 0 until done rises. The wait is capped at 100
    // cycles; if it runs out, the returned latency is -1.
    task automatic waitDone(output int latOut);
        latOut = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (done) begin
                latOut = i;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset divzero", 64'(divzero), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF with a cycle-exact timeline.
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("multu busy e0", 64'(busy), 64'd1);
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 1 || e == 16 || e == 32) begin
                checkOutput($sformatf("multu busy e%0d", e), 64'(busy), 64'd1);
                checkOutput($sformatf("multu done e%0d", e), 64'(done), 64'd0);
                checkOutput($sformatf("multu lo hold e%0d", e), 64'(lo), 64'd0);
            end
        end
        tick();
        checkOutput("multu done e33", 64'(done), 64'd1);
        checkOutput("multu busy e33", 64'(busy), 64'd0);
        checkOutput("multu hi", 64'(hi), 64'hFFFF_FFFE);
        checkOutput("multu lo", 64'(lo), 64'h0000_0001);
        tick();
        checkOutput("multu done fall", 64'(done), 64'd0);

        // DIVU 100 / 7.
        applyStimulus(2'b01, 32'd100, 32'd7);
        waitDone(lat);
        checkOutput("divu latency", 64'(lat), 64'd33);
        checkOutput("divu lo", 64'(lo), 64'd14);
        checkOutput("divu hi", 64'(hi), 64'd2);
        checkOutput("divu divzero", 64'(divzero), 64'd0);

        // DIV -7 / 2; the expected values depend on the build.
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'd2);
        waitDone(lat);
        checkOutput("div latency", 64'(lat), 64'd33);
`ifdef MUL_DIV_UNIT_SIGNED_EN
        checkOutput("div lo", 64'(lo), 64'hFFFF_FFFD);
        checkOutput("div hi", 64'(hi), 64'hFFFF_FFFF);
`else
        checkOutput("div lo", 64'(lo), 64'h7FFF_FFFC);
        checkOutput("div hi", 64'(hi), 64'h0000_0001);
`endif

        // MULT 0xFFFFFFFE * 3; the expected values depend on the build.
        applyStimulus(2'b10, 32'hFFFF_FFFE, 32'd3);
        waitDone(lat);
        checkOutput("mult latency", 64'(lat), 64'd33);
`ifdef MUL_DIV_UNIT_SIGNED_EN
        checkOutput("mult hi", 64'(hi), 64'hFFFF_FFFF);
        checkOutput("mult lo", 64'(lo), 64'hFFFF_FFFA);
`else
        checkOutput("mult hi", 64'(hi), 64'h0000_0002);
        checkOutput("mult lo", 64'(lo), 64'hFFFF_FFFA);
`endif

        // DIVU 5 / 0, then MULTU 3 * 4 clears divzero.
        applyStimulus(2'b01, 32'd5, 32'd0);
        waitDone(lat);
        checkOutput("div0 latency", 64'(lat), 64'd1);
        checkOutput("div0 hi", 64'(hi), 64'd5);
        checkOutput("div0 lo", 64'(lo), 64'hFFFF_FFFF);
        checkOutput("div0 divzero", 64'(divzero), 64'd1);
        applyStimulus(2'b00, 32'd3, 32'd4);
        checkOutput("divzero clear", 64'(divzero), 64'd0);
        waitDone(lat);
        checkOutput("mul34 lo", 64'(lo), 64'd12);
        checkOutput("mul34 divzero", 64'(divzero), 64'd0);

        // A second start and a lo_we arriving during RUN are both ignored.
        applyStimulus(2'b00, 32'd6, 32'd7);
        for (int e = 1; e <= 5; e++) tick();
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd9;
        b     = 32'd3;
        lo_we = 1'b1;
        wdata = 32'h1234;
        tick();
        start = 1'b0;
        lo_we = 1'b0;
        checkOutput("run lo_we dropped", 64'(lo), 64'd12);
        waitDone(lat);
        checkOutput("restart ignored latency", 64'(lat + 6), 64'd33);
        checkOutput("mul67 lo", 64'(lo), 64'd42);
        checkOutput("mul67 hi", 64'(hi), 64'd0);
        tick();

        // Direct writes while IDLE.
        lo_we = 1'b1;
        wdata = 32'h1234;
        tick();
        lo_we = 1'b0;
        checkOutput("idle lo_we", 64'(lo), 64'h1234);
        hi_we = 1'b1;
        wdata = 32'hABCD;
        tick();
        hi_we = 1'b0;
        checkOutput("idle hi_we", 64'(hi), 64'hABCD);

        // A start in the same cycle as lo_we wins, so the write is dropped.
        lo_we = 1'b1;
        wdata = 32'h5555;
        applyStimulus(2'b00, 32'd2, 32'd3);
        lo_we = 1'b0;
        checkOutput("start beats lo_we", 64'(lo), 64'h1234);
        waitDone(lat);
        checkOutput("mul23 lo", 64'(lo), 64'd6);

        // Asynchronous reset in mid-RUN, between edges.
        tick();
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        tick();
        hi_we = 1'b0;
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int e = 1; e <= 10; e++) tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(busy), 64'd0);
        checkOutput("async reset hi", 64'(hi), 64'd0);
        checkOutput("async reset lo", 64'(lo), 64'd0);
        tick();
        reset = 1'b0;
        sawDone = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (done) sawDone = 1;
        end
        checkOutput("no done after reset", 64'(sawDone), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
